nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs a WIDTH-bit add, or a subtract when the optional feature is compiled in, by time-multiplexing one 4-bit carry-lookahead slice across the operand nibbles, LSB first, one nibble per clock. A ready/valid handshake sits on both input and output, and the carry is held in a register between nibbles. Serves as the wide-add engine of the ULA datapath when area matters more than latency.

---
 rtl/nsa_pkg.sv | 17 +
 rtl/behave_4bit_carry_lookahead_adder.sv | 31 +++
 rtl/nibble_serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Width of the nibble index; never narrower than one bit.
  function automatic int idx_width(input int num_nib);
    return (num_nib > 1) ? $clog2(num_nib) : 1;
  endfunction

endpackage

// File: rtl/behave_4bit_carry_lookahead_adder.sv
// 4-bit carry-lookahead slice; propagador is the MSB propagate term a[3]^b[3].
module behave_4bit_carry_lookahead_adder
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             propagador
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s          = p ^ c[NIB_W-1:0];
  assign cout       = c[NIB_W];
  assign propagador = p[NIB_W-1];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built by reusing one 4-bit CLA slice per nibble, LSB first.
// Define NSA_SUB_EN to enable subtraction via op_sub.
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NUM_NIB = WIDTH / NIB_W;
  localparam int IDX_W   = idx_width(NUM_NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] b_in;
  logic             carry_init;
  logic [WIDTH-1:0] sum_nxt;

  logic [NIB_W-1:0] slice_s;
  logic             slice_cout;
  logic             slice_p;

`ifdef NSA_SUB_EN
  assign b_in       = op_sub ? ~op_b : op_b;
  assign carry_init = op_sub ? 1'b1 : op_cin;
`else
  logic unused_sub;
  assign unused_sub = op_sub;
  assign b_in       = op_b;
  assign carry_init = op_cin;
`endif

  behave_4bit_carry_lookahead_adder u_slice (
    .a          (a_q[NIB_W*idx +: NIB_W]),
    .b          (b_q[NIB_W*idx +: NIB_W]),
    .cin        (carry_q),
    .s          (slice_s),
    .cout       (slice_cout),
    .propagador (slice_p)
  );

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (idx == LAST_IDX) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result as it will look once the current nibble lands.
  always_comb begin
    sum_nxt = sum;
    sum_nxt[NIB_W*idx +: NIB_W] = slice_s;
  end

  // NOTE: operand registers need no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= op_a;
      b_q <= b_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        idx     <= '0;
        carry_q <= carry_init;
      end else if (state_q == RUN) begin
        sum     <= sum_nxt;
        carry_q <= slice_cout;
        idx     <= idx + IDX_W'(1);
        if (idx == LAST_IDX) begin
          cout <= slice_cout;
          // Sum[3]^propagate recovers the carry into the MSB.
          ovf  <= slice_cout ^ (slice_s[NIB_W-1] ^ slice_p);
          zero <= (sum_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed and random operations against an arithmetic model.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH   = 16;
  localparam int NUM_NIB = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic sub,
                                output logic [WIDTH-1:0] s, output logic c,
                                output logic v, output logic z);
    longint ua, ub, sa, sb, r, sr;
    longint smax, smin;
    bit     do_sub;
    do_sub = 1'b0;
`ifdef NSA_SUB_EN
    do_sub = sub;
`else
    if (sub) do_sub = 1'b0;
`endif
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    if (do_sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(cin);
      c  = (r >= (longint'(1) << WIDTH));
      sr = sa + sb + longint'(cin);
    end
    s = r[WIDTH-1:0];
    v = (sr > smax) || (sr < smin);
    z = (s == '0);
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [WIDTH-1:0] es;
    logic             ec, ev, ez;
    int               cycles;
    model(a, b, cin, sub, es, ec, ev, ez);
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    op_sub   = sub;
    check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = WIDTH'($urandom);
    op_b     = WIDTH'($urandom);
    op_cin   = 1'($urandom);
    op_sub   = 1'($urandom);
    cycles   = 0;
    while (!out_valid && cycles < 4 * NUM_NIB) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", cycles, NUM_NIB);
    check("out_valid", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("ovf", ovf, ev);
    check("zero", zero, ez);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_a     = WIDTH'($urandom);
      op_b     = WIDTH'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, es);
      check("hold_flags", {cout, ovf, zero}, {ec, ev, ez});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_sum_kept", sum, es);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    op_sub    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ovf, zero}, 3'b000);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 3);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
`ifdef NSA_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 0);
`endif

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 16'h1111;
    op_b     = 16'h1111;
    op_cin   = 1'b0;
    op_sub   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (k % 7 == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
